// File: rtl/ram_ctrl.sv
// Purpose: word-addressed backing RAM behind the instruction/data arbiter port, with a fixed access delay.
// Latency: busy_o is high for LATENCY+1 cycles per request, and the access commits on the edge into READY.
// Backpressure: busy_o holds the requester; dropping Ren/Wen during WAIT aborts the access with no side effects.
module ram_ctrl #(
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2,
    parameter logic [31:0] BADDATA = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        Ren,
    input  logic        Wen,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic        busy_o,
    output logic        err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;

    // Request captured on acceptance; later changes on the port are ignored.
    logic [29:0] lat_idx;
    logic [31:0] lat_dat;
    logic        lat_wr;

    logic        req;
    logic        start;
    logic        commit;
    logic        in_range;

    // The two address offset bits are don't-care for a word-only memory.
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^ramaddr[1:0];

    logic [31:0] mem [DEPTH];

    // Request decode and commit qualification.
    always_comb begin
        req      = Ren | Wen;
        start    = (state == ST_IDLE) && req;
        commit   = (state == ST_WAIT) && req && (cnt == 4'd0);
        in_range = ({2'b00, lat_idx} < 32'(DEPTH));
    end

    // Next-state, wait counter and busy output.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy_o    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    busy_o    = 1'b1;
                    cnt_nxt   = 4'(LATENCY - 1);
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy_o = 1'b1;
                if (!req) begin
                    state_nxt = ST_IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Latch the request on acceptance; write beats Read when both are raised.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lat_idx <= '0;
            lat_dat <= '0;
            lat_wr  <= 1'b0;
        end else if (start) begin
            lat_idx <= ramaddr[31:2];
            lat_dat <= ramstore;
            lat_wr  <= Wen;
        end
    end

    // Read data register: only a read commit or reset changes it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ramload <= 32'h0;
        end else if (commit && !lat_wr) begin
            ramload <= in_range ? mem[lat_idx[AW-1:0]] : BADDATA;
        end
    end

    // Error pulse: set at an out-of-range commit, cleared when READY ends.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_o <= 1'b0;
        end else if (commit) begin
            err_o <= !in_range;
        end else if (state == ST_READY) begin
            err_o <= 1'b0;
        end
    end

    // Array write at commit; contents survive reset and out-of-range writes are dropped.
    always_ff @(posedge CLK) begin
        if (commit && lat_wr && in_range) begin
            mem[lat_idx[AW-1:0]] <= lat_dat;
        end
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed, table-driven bench for ram_ctrl at DEPTH=1024, LATENCY=2.
// Inputs are driven 1ns after the rising edge or on the falling edge, and outputs are sampled on the falling edge.
// Multi-cycle corner cases (abort, address change in WAIT, reset mid-WAIT) are written as explicit sequences.
module tb_ram_ctrl;

    localparam int LAT = 2;

    logic        CLK;
    logic        nRST;
    logic        Ren;
    logic        Wen;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        busy_o;
    logic        err_o;

    int total = 0;
    int bad   = 0;

    ram_ctrl #(
        .DEPTH  (1024),
        .LATENCY(LAT),
        .BADDATA(32'hBAD1BAD1)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .Ren     (Ren),
        .Wen     (Wen),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_load;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One complete access: raise the request, count the busy cycles, check the READY cycle, then the cycle after it.
    task automatic do_access(input string nm, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] exp_load, input logic exp_err);
        int  n;
        bit  done;
        @(posedge CLK); #1;
        Ren = rd; Wen = wr; ramaddr = a; ramstore = d;
        n = 0;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLK);
            if (busy_o) n++;
            else done = 1;
        end
        chk({nm, " busy_cycles"}, 32'(n), 32'(LAT + 1));
        chk({nm, " ramload"}, ramload, exp_load);
        chk({nm, " err_ready"}, {31'b0, err_o}, {31'b0, exp_err});
        Ren = 1'b0; Wen = 1'b0;
        @(negedge CLK);
        chk({nm, " err_after"}, {31'b0, err_o}, 32'h0);
        chk({nm, " busy_after"}, {31'b0, busy_o}, 32'h0);
        chk({nm, " load_hold"}, ramload, exp_load);
    endtask

    initial begin
        int n;
        bit done;

        //           rd    wr    addr          data          exp_load      err
        vecs[0]  = '{1'b0, 1'b1, 32'h00000040, 32'h33333333, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h00000040, 32'h0,        32'h33333333, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'h00000010, 32'hABCDABCD, 32'h33333333, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h00000010, 32'h0,        32'hABCDABCD, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h00000040, 32'h12341234, 32'hABCDABCD, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h00000043, 32'h0,        32'h12341234, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h00000020, 32'h00000000, 32'h12341234, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h00000030, 32'h5A5A5A5A, 32'h12341234, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h00000000, 32'hCAFEF00D, 32'h12341234, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h00000FFC, 32'h0F0F0F0F, 32'h12341234, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h00000FFC, 32'h0,        32'h0F0F0F0F, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h00001000, 32'h0,        32'hBAD1BAD1, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'h00001000, 32'h77777777, 32'hBAD1BAD1, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 32'h00000000, 32'h0,        32'hCAFEF00D, 1'b0};

        Ren = 1'b0; Wen = 1'b0; ramaddr = '0; ramstore = '0;
        nRST = 1'b0;
        #12;
        chk("reset busy", {31'b0, busy_o}, 32'h0);
        chk("reset ramload", ramload, 32'h0);
        chk("reset err", {31'b0, err_o}, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
                      vecs[i].data, vecs[i].exp_load, vecs[i].exp_err);
        end

        // Abort: the write of 0x55555555 to 0x20 is withdrawn in the second WAIT cycle.
        @(posedge CLK); #1;
        Wen = 1'b1; ramaddr = 32'h20; ramstore = 32'h55555555;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        Wen = 1'b0;
        @(negedge CLK);
        chk("abort busy_wait", {31'b0, busy_o}, 32'h1);
        @(negedge CLK);
        chk("abort busy_idle", {31'b0, busy_o}, 32'h0);
        chk("abort err", {31'b0, err_o}, 32'h0);
        chk("abort load_hold", ramload, 32'hCAFEF00D);
        @(negedge CLK);
        chk("abort err_late", {31'b0, err_o}, 32'h0);
        do_access("abort readback", 1'b1, 1'b0, 32'h20, 32'h0, 32'h00000000, 1'b0);

        // The address is changed during WAIT; the latched 0x40 must still be used.
        @(posedge CLK); #1;
        Ren = 1'b1; ramaddr = 32'h40;
        @(posedge CLK); #1;
        ramaddr = 32'h10;
        n = 1;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge CLK);
            if (busy_o) n++;
            else done = 1;
        end
        chk("addr_change busy_cycles", 32'(n), 32'(LAT + 1));
        chk("addr_change ramload", ramload, 32'h12341234);
        Ren = 1'b0;
        @(negedge CLK);

        // Reset arrives between edges while a write of 0x99999999 to 0x30 is in WAIT.
        @(posedge CLK); #1;
        Wen = 1'b1; ramaddr = 32'h30; ramstore = 32'h99999999;
        @(posedge CLK); #1;
        #2;
        Wen = 1'b0;
        nRST = 1'b0;
        #1;
        chk("midreset busy", {31'b0, busy_o}, 32'h0);
        chk("midreset ramload", ramload, 32'h0);
        chk("midreset err", {31'b0, err_o}, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        do_access("midreset readback", 1'b1, 1'b0, 32'h30, 32'h0, 32'h5A5A5A5A, 1'b0);

        // Out-of-range write earlier must not have touched word 0; the last in-range word is still intact.
        do_access("spot idx0", 1'b1, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);
        do_access("spot idx1023", 1'b1, 1'b0, 32'hFFC, 32'h0, 32'h0F0F0F0F, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
